instr_sequencer: RTL and testbench
==================================

// Module: instr_sequencer
// PURPOSE
//   Upstream control stage for the 4x32 regfile + ALU32 datapath. Buffers 12-bit
//   instruction words in a small FIFO and decodes one per cycle into datapath
//   controls (ALUControl, addr1/2/3, wr). Consumes Zero/Overflow back from the
//   datapath for skip-if-zero and overflow-trap handling.
// PARAMETERS
//   DEPTH  4   instruction FIFO entries (power of 2, >=2)
//   IW     12  instruction word width (field map below is fixed for 12)
// PORTS
//   clk         in   1   rising-edge clock
//   rst         in   1   asynchronous, active-low reset
//   in_valid    in   1   producer presents in_instr
//   in_ready    out  1   FIFO can accept; push when in_valid & in_ready
//   in_instr    in   IW  [11:9]op [8:7]rd [6:5]rs1 [4:3]rs2 [2]we [1:0]cls
//   Zero        in   1   datapath Zero for currently issued op
//   Overflow    in   1   datapath Overflow for currently issued op
//   clear       in   1   leaves HALT/TRAP, returns to RUN
//   ALUControl  out  3   = op of issued word (000 add, 001 sub, ...)
//   addr1       out  2   = rs1;  addr2 out 2 = rs2;  addr3 out 2 = rd
//   wr          out  1   regfile write enable, one cycle per issued ALU word with we=1
//   issue_valid out  1   controls above carry a live instruction this cycle
//   halted      out  1   state == HALT
//   trap        out  1   state == TRAP
//   count       out  $clog2(DEPTH)+1  FIFO occupancy
// BEHAVIOUR
//   Reset (rst=0, async): FIFO empty, count=0, state RUN, zflag=0, all control
//     outputs 0, issue_valid/wr/halted/trap=0. Reset mid-operation drops all
//     buffered and in-flight words; no wr pulse is produced from them.
//   FIFO: in_ready = (count<DEPTH). Push and pop in same cycle legal (count holds).
//     No bypass: a word pushed into empty FIFO is popped the next cycle at earliest.
//   Pop only in RUN or SKIP with count>0. Latency: popped word drives registered
//     outputs on the following cycle; outputs are held for exactly one cycle.
//   cls decode at pop:
//     00 ALU : issue_valid=1, wr=we, fields passed through.
//     01 NOP : issue_valid=0, wr=0.
//     10 HALT: no issue; state->HALT.
//     11 SKZ : no issue; if zflag=1 state->SKIP.
//   zflag: captured from Zero on every cycle issue_valid=1; unchanged otherwise.
//   SKIP: next popped word is discarded (any cls, HALT included), then RUN.
//     Empty FIFO in SKIP waits in SKIP.
//   TRAP: Overflow=1 while issue_valid=1 & wr=1 -> state TRAP next cycle; the
//     overflowing write still completes (already at edge). The word popped in
//     the same cycle is kept at FIFO head (pop suppressed / not consumed).
//   HALT/TRAP: no pops, outputs idle (issue_valid=0, wr=0); FIFO still accepts.
//     clear=1 -> RUN next cycle. clear in RUN/SKIP ignored.
//   Priority when simultaneous: reset > trap detect > clear > decode.
// STRUCTURE
//   Shared package: cls codes (CLS_ALU/NOP/HALT/SKZ), state encoding
//     (S_RUN/S_SKIP/S_HALT/S_TRAP), ALU op constants, instruction field offsets.
//   One sub-module: instr_fifo (DEPTH x IW, count, full/empty, async active-low
//     reset). Decode + FSM + output registers live in instr_sequencer.
//   Pairs with datapath; top wires ALUControl/addr*/wr through, Zero/Overflow back.
// TESTING
//   1 reset: drive rst=0 mid-burst with 3 words queued -> count=0, wr=0,
//     issue_valid=0 immediately; after release no stale wr pulse.
//   2 basic: push ALU sub rd=2 rs1=1 rs2=3 we=1 -> one cycle later ALUControl=001,
//     addr1=1 addr2=3 addr3=2 wr=1 issue_valid=1 for exactly one cycle.
//   3 full FIFO: push 5 words back-to-back with pops blocked by HALT -> in_ready=0
//     at count=4, 5th held; clear -> drains in order, one issue per cycle.
//   4 SKZ: issue R1-R1 (Zero=1), then SKZ, then ALU X, ALU Y -> X discarded
//     (no wr), Y issued; repeat with Zero=0 -> X and Y both issued.
//   5 trap: issue add with Overflow forced 1 -> trap=1 next cycle, following
//     word stays queued (count unchanged); clear=1 -> trap=0, word issues.
//   6 HALT: queue ALU, HALT, ALU -> first issues, halted=1, third waits; clear
//     -> third issues; HALT in SKIP slot is skipped, halted stays 0.

Source files
------------

// File: rtl/instr_sequencer_pkg.sv
// ============================================================================
// Module : instr_sequencer_pkg
// Brief  : Shared instruction codes, FSM states and field layout
// Rev    : 1.0
// ============================================================================
`default_nettype none

package instr_sequencer_pkg;

  localparam int INSTR_W = 12;

  localparam logic [1:0] CLS_ALU  = 2'b00;
  localparam logic [1:0] CLS_NOP  = 2'b01;
  localparam logic [1:0] CLS_HALT = 2'b10;
  localparam logic [1:0] CLS_SKZ  = 2'b11;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;

  localparam int OP_LSB  = 9;
  localparam int RD_LSB  = 7;
  localparam int RS1_LSB = 5;
  localparam int RS2_LSB = 3;
  localparam int WE_BIT  = 2;
  localparam int CLS_LSB = 0;

  typedef enum logic [1:0] {
    S_RUN  = 2'b00,
    S_SKIP = 2'b01,
    S_HALT = 2'b10,
    S_TRAP = 2'b11
  } state_e;

  typedef struct packed {
    logic [2:0] op;
    logic [1:0] rd;
    logic [1:0] rs1;
    logic [1:0] rs2;
    logic       we;
    logic [1:0] cls;
  } instr_t;

  function automatic instr_t decode_instr(input logic [INSTR_W-1:0] w);
    instr_t d;
    d.op  = w[OP_LSB  +: 3];
    d.rd  = w[RD_LSB  +: 2];
    d.rs1 = w[RS1_LSB +: 2];
    d.rs2 = w[RS2_LSB +: 2];
    d.we  = w[WE_BIT];
    d.cls = w[CLS_LSB +: 2];
    return d;
  endfunction

endpackage

`default_nettype wire

// File: rtl/instr_sequencer_if.sv
// ============================================================================
// Module : instr_sequencer_if
// Brief  : Producer/datapath-facing bus of the instruction sequencer
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface instr_sequencer_if #(
  parameter int IW = 12,
  parameter int CW = 3
);
  logic          in_valid;
  logic          in_ready;
  logic [IW-1:0] in_instr;
  logic          Zero;
  logic          Overflow;
  logic          clear;
  logic [2:0]    ALUControl;
  logic [1:0]    addr1;
  logic [1:0]    addr2;
  logic [1:0]    addr3;
  logic          wr;
  logic          issue_valid;
  logic          halted;
  logic          trap;
  logic [CW-1:0] count;

  modport master (
    output in_valid, in_instr, Zero, Overflow, clear,
    input  in_ready, ALUControl, addr1, addr2, addr3, wr,
           issue_valid, halted, trap, count
  );

  modport slave (
    input  in_valid, in_instr, Zero, Overflow, clear,
    output in_ready, ALUControl, addr1, addr2, addr3, wr,
           issue_valid, halted, trap, count
  );
endinterface

`default_nettype wire

// File: rtl/instr_sequencer_fifo.sv
// ============================================================================
// Module : instr_fifo
// Brief  : DEPTH x W instruction FIFO with occupancy count, no bypass
// Rev    : 1.0
// ============================================================================
`default_nettype none

module instr_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 12
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic [W-1:0]           data_i,
  input  logic                   pop_i,
  output logic [W-1:0]           data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [W-1:0]  mem_q [DEPTH];
  logic          w_push;
  logic          w_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];
  assign w_push  = push_i & ~full_o;
  assign w_pop   = pop_i & ~empty_o;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (w_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (w_push && !w_pop)      count_q <= count_q + CW'(1);
      else if (!w_push && w_pop) count_q <= count_q - CW'(1);
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (w_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

`default_nettype wire

// File: rtl/instr_sequencer.sv
// ============================================================================
// Module : instr_sequencer
// Brief  : Buffers instruction words and issues one per cycle to the datapath
// Rev    : 1.0
// ============================================================================
`default_nettype none

module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int IW    = 12
) (
  input  logic               clk,
  input  logic               rst,
  instr_sequencer_if.slave   bus
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [IW-1:0] fifo_rdata;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  instr_t        head;
  logic          w_trap_det;
  logic          w_pop;

  state_e        state_q;
  logic          zflag_q;
  logic          issue_valid_q;
  logic          wr_q;
  logic [2:0]    alu_q;
  logic [1:0]    addr1_q;
  logic [1:0]    addr2_q;
  logic [1:0]    addr3_q;

  instr_fifo #(
    .DEPTH (DEPTH),
    .W     (IW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (bus.in_valid),
    .data_i  (bus.in_instr),
    .pop_i   (w_pop),
    .data_o  (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign head       = decode_instr(fifo_rdata);
  assign w_trap_det = issue_valid_q & wr_q & bus.Overflow;
  // A trapping cycle leaves the head word in place so it issues after clear.
  assign w_pop      = ((state_q == S_RUN) || (state_q == S_SKIP)) &&
                      !fifo_empty && !w_trap_det;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_RUN;
      zflag_q       <= 1'b0;
      issue_valid_q <= 1'b0;
      wr_q          <= 1'b0;
      alu_q         <= '0;
      addr1_q       <= '0;
      addr2_q       <= '0;
      addr3_q       <= '0;
    end else begin
      issue_valid_q <= 1'b0;
      wr_q          <= 1'b0;
      alu_q         <= '0;
      addr1_q       <= '0;
      addr2_q       <= '0;
      addr3_q       <= '0;

      if (issue_valid_q) zflag_q <= bus.Zero;

      if (w_trap_det) begin
        state_q <= S_TRAP;
      end else begin
        case (state_q)
          S_HALT, S_TRAP: begin
            if (bus.clear) state_q <= S_RUN;
          end
          S_SKIP: begin
            if (w_pop) state_q <= S_RUN;
          end
          default: begin
            if (w_pop) begin
              case (head.cls)
                CLS_ALU: begin
                  issue_valid_q <= 1'b1;
                  wr_q          <= head.we;
                  alu_q         <= head.op;
                  addr1_q       <= head.rs1;
                  addr2_q       <= head.rs2;
                  addr3_q       <= head.rd;
                end
                CLS_HALT: state_q <= S_HALT;
                CLS_SKZ: begin
                  if (zflag_q) state_q <= S_SKIP;
                end
                default: ;
              endcase
            end
          end
        endcase
      end
    end
  end

  assign bus.in_ready    = ~fifo_full;
  assign bus.count       = fifo_count;
  assign bus.ALUControl  = alu_q;
  assign bus.addr1       = addr1_q;
  assign bus.addr2       = addr2_q;
  assign bus.addr3       = addr3_q;
  assign bus.wr          = wr_q;
  assign bus.issue_valid = issue_valid_q;
  assign bus.halted      = (state_q == S_HALT);
  assign bus.trap        = (state_q == S_TRAP);

endmodule

`default_nettype wire

// File: tb/tb_instr_sequencer.sv
// ============================================================================
// Module : tb_instr_sequencer
// Brief  : Directed self-checking bench for instr_sequencer
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_instr_sequencer;
  import instr_sequencer_pkg::*;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_bad;
  int   wr_cnt;
  int   iss_cnt;
  logic [3:0] wr_mask;

  instr_sequencer_if #(.IW(12), .CW(3)) bus ();

  instr_sequencer #(.DEPTH(4), .IW(12)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] mk(input logic [2:0] op, input logic [1:0] rd,
                                     input logic [1:0] rs1, input logic [1:0] rs2,
                                     input logic we, input logic [1:0] cls);
    return {op, rd, rs1, rs2, we, cls};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (bus.wr) begin
      wr_cnt++;
      wr_mask[bus.addr3] = 1'b1;
    end
    if (bus.issue_valid) iss_cnt++;
  endtask

  task automatic mon_clr();
    wr_cnt  = 0;
    iss_cnt = 0;
    wr_mask = 4'b0000;
  endtask

  task automatic push1(input logic [11:0] w);
    bus.in_valid = 1'b1;
    bus.in_instr = w;
    tick();
    bus.in_valid = 1'b0;
  endtask

  // Issues a R1-R1 ALU op and presents the given Zero during its issue cycle.
  task automatic set_zflag(input logic z);
    push1(mk(OP_SUB, 2'd1, 2'd1, 2'd1, 1'b1, CLS_ALU));
    tick();
    bus.Zero = z;
    tick();
    bus.Zero = 1'b0;
  endtask

  initial begin
    n_chk = 0;
    n_bad = 0;
    mon_clr();
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_instr = '0;
    bus.Zero     = 1'b0;
    bus.Overflow = 1'b0;
    bus.clear    = 1'b0;
    #2;
    check("rst_count", 32'(bus.count), 0);
    check("rst_iv", 32'(bus.issue_valid), 0);
    check("rst_wr", 32'(bus.wr), 0);
    check("rst_ready", 32'(bus.in_ready), 1);
    check("rst_halt_trap", 32'({bus.halted, bus.trap}), 0);
    tick();
    rst = 1'b1;

    // basic issue
    push1(mk(OP_SUB, 2'd2, 2'd1, 2'd3, 1'b1, CLS_ALU));
    check("basic_cnt", 32'(bus.count), 1);
    check("basic_iv_early", 32'(bus.issue_valid), 0);
    tick();
    check("basic_iv", 32'(bus.issue_valid), 1);
    check("basic_alu", 32'(bus.ALUControl), 1);
    check("basic_addr", 32'({bus.addr1, bus.addr2, bus.addr3}), 32'b01_11_10);
    check("basic_wr", 32'(bus.wr), 1);
    tick();
    check("basic_iv_off", 32'(bus.issue_valid), 0);
    check("basic_wr_off", 32'(bus.wr), 0);

    // full FIFO behind HALT, then drain in order
    push1(mk(OP_ADD, 2'd0, 2'd0, 2'd0, 1'b0, CLS_HALT));
    tick();
    check("full_halted", 32'(bus.halted), 1);
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.in_instr = mk(3'(i), 2'(i), 2'd0, 2'd1, 1'b1, CLS_ALU);
      if (i < 4) check("full_ready", 32'(bus.in_ready), 1);
      if (i < 4) tick();
    end
    check("full_ready_low", 32'(bus.in_ready), 0);
    check("full_cnt", 32'(bus.count), 4);
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    check("full_clear", 32'(bus.halted), 0);
    check("full_cnt_hold", 32'(bus.count), 4);
    for (int k = 0; k < 5; k++) begin
      tick();
      if (k == 1) bus.in_valid = 1'b0;
      check("drain_iv", 32'(bus.issue_valid), 1);
      check("drain_op", 32'(bus.ALUControl), 32'(k));
    end
    check("drain_empty", 32'(bus.count), 0);

    // SKZ with zflag=1: X discarded, Y issued
    set_zflag(1'b1);
    push1(mk(OP_ADD, 2'd0, 2'd0, 2'd0, 1'b0, CLS_SKZ));
    mon_clr();
    tick();
    bus.in_valid = 1'b1;
    bus.in_instr = mk(OP_ADD, 2'd2, 2'd1, 2'd1, 1'b1, CLS_ALU);
    tick();
    bus.in_instr = mk(OP_ADD, 2'd3, 2'd1, 2'd1, 1'b1, CLS_ALU);
    tick();
    bus.in_valid = 1'b0;
    repeat (4) tick();
    check("skz1_wrcnt", 32'(wr_cnt), 1);
    check("skz1_mask", 32'(wr_mask), 32'b1000);

    // SKZ with zflag=0: X and Y both issued
    set_zflag(1'b0);
    push1(mk(OP_ADD, 2'd0, 2'd0, 2'd0, 1'b0, CLS_SKZ));
    mon_clr();
    tick();
    bus.in_valid = 1'b1;
    bus.in_instr = mk(OP_ADD, 2'd2, 2'd1, 2'd1, 1'b1, CLS_ALU);
    tick();
    bus.in_instr = mk(OP_ADD, 2'd3, 2'd1, 2'd1, 1'b1, CLS_ALU);
    tick();
    bus.in_valid = 1'b0;
    repeat (4) tick();
    check("skz0_wrcnt", 32'(wr_cnt), 2);
    check("skz0_mask", 32'(wr_mask), 32'b1100);

    // overflow trap keeps the next word queued
    bus.in_valid = 1'b1;
    bus.in_instr = mk(OP_ADD, 2'd1, 2'd0, 2'd1, 1'b1, CLS_ALU);
    tick();
    bus.in_instr = mk(OP_AND, 2'd2, 2'd3, 2'd0, 1'b1, CLS_ALU);
    tick();
    bus.in_valid = 1'b0;
    check("trap_pre_iv", 32'(bus.issue_valid), 1);
    bus.Overflow = 1'b1;
    tick();
    bus.Overflow = 1'b0;
    check("trap_set", 32'(bus.trap), 1);
    check("trap_cnt", 32'(bus.count), 1);
    check("trap_iv", 32'(bus.issue_valid), 0);
    tick();
    check("trap_hold", 32'({bus.trap, bus.issue_valid}), 32'b10);
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    check("trap_clr", 32'(bus.trap), 0);
    check("trap_clr_cnt", 32'(bus.count), 1);
    tick();
    check("trap_resume_iv", 32'(bus.issue_valid), 1);
    check("trap_resume_op", 32'({bus.ALUControl, bus.addr3}), 32'b010_10);
    check("trap_resume_cnt", 32'(bus.count), 0);

    // HALT between two ALU words
    mon_clr();
    bus.in_valid = 1'b1;
    bus.in_instr = mk(OP_ADD, 2'd1, 2'd0, 2'd0, 1'b1, CLS_ALU);
    tick();
    bus.in_instr = mk(OP_ADD, 2'd0, 2'd0, 2'd0, 1'b0, CLS_HALT);
    tick();
    bus.in_instr = mk(OP_OR, 2'd3, 2'd2, 2'd2, 1'b1, CLS_ALU);
    tick();
    bus.in_valid = 1'b0;
    check("halt_set", 32'(bus.halted), 1);
    check("halt_first", 32'(wr_mask), 32'b0010);
    repeat (3) tick();
    check("halt_wait", 32'({bus.halted, bus.issue_valid}), 32'b10);
    check("halt_cnt", 32'(bus.count), 1);
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    check("halt_clr", 32'(bus.halted), 0);
    tick();
    check("halt_third", 32'({bus.issue_valid, bus.ALUControl, bus.addr3}), 32'b1_011_11);

    // HALT in SKIP slot is discarded
    set_zflag(1'b1);
    push1(mk(OP_ADD, 2'd0, 2'd0, 2'd0, 1'b0, CLS_SKZ));
    tick();
    push1(mk(OP_ADD, 2'd0, 2'd0, 2'd0, 1'b0, CLS_HALT));
    tick();
    check("skiphalt_halted", 32'(bus.halted), 0);
    check("skiphalt_cnt", 32'(bus.count), 0);
    mon_clr();
    push1(mk(OP_ADD, 2'd2, 2'd0, 2'd0, 1'b1, CLS_ALU));
    repeat (2) tick();
    check("skiphalt_run", 32'(wr_mask), 32'b0100);

    // reset mid-burst with words queued
    push1(mk(OP_ADD, 2'd0, 2'd0, 2'd0, 1'b0, CLS_HALT));
    tick();
    bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.in_instr = mk(OP_ADD, 2'(i), 2'd1, 2'd2, 1'b1, CLS_ALU);
      tick();
    end
    bus.in_valid = 1'b0;
    check("burst_cnt", 32'(bus.count), 3);
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    tick();
    check("burst_wr", 32'(bus.wr), 1);
    rst = 1'b0;
    #1;
    check("mrst_cnt", 32'(bus.count), 0);
    check("mrst_wr_iv", 32'({bus.wr, bus.issue_valid}), 0);
    tick();
    rst = 1'b1;
    mon_clr();
    repeat (5) tick();
    check("mrst_no_stale", 32'(wr_cnt + iss_cnt), 0);
    check("mrst_cnt_after", 32'(bus.count), 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
